// File: rtl/stopwatch_ctrl_if.sv
// Control bus between the stopwatch sequencer (master) and the 8-bit counter core (slave).
interface stopwatch_ctrl_if;
   logic       ctr_ce;
   logic       ctr_up;
   logic       ctr_sclr;
   logic       ctr_load;
   logic [7:0] ctr_din;
   logic [7:0] count;

   modport master (
      output ctr_ce, ctr_up, ctr_sclr, ctr_load, ctr_din,
      input  count
   );

   modport slave (
      input  ctr_ce, ctr_up, ctr_sclr, ctr_load, ctr_din,
      output count
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: button events -> counter controls, 1 s tick prescaler, lap-hold display mux.
// Lap-hold logic is built only when STOPWATCH_LAP_EN is defined.
//
// state | meaning
// IDLE  | stopped, prescaler cleared, waiting for start
// RUN   | counting, display follows count
// PAUSE | stopped, prescaler holds its partial second
// LAP   | counting, display frozen on lap_reg
// DONE  | terminal value reached, only clear exits
module stopwatch_ctrl #(
   parameter int unsigned TICK_DIV  = 5_000_000,
   parameter logic [7:0]  MAX_COUNT = 8'd99
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    btn_start,
   input  logic                    btn_lap,
   input  logic                    btn_clear,
   input  logic                    dir_dn,
   stopwatch_ctrl_if.master        ctr,
   output logic [7:0]              display,
   output logic [2:0]              state,
   output logic                    done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_RUN   = 3'd1,
      S_PAUSE = 3'd2,
      S_LAP   = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   localparam logic [22:0] TICK_LAST = 23'(TICK_DIV - 1);

   state_t      st;
   logic [2:0]  btn_s;
   logic [2:0]  btn_q;
   logic [22:0] presc;
   logic        ev_clear;
   logic        ev_start;
   logic        ev_lap;
   logic        tick;
   logic        running;
   logic        at_term;

`ifdef STOPWATCH_LAP_EN
   logic [7:0]  lap_reg;
   logic        resume_lap;
`endif

   // btn_s is the sample flop, btn_q the previous value: {clear, start, lap}
   assign ev_clear = btn_s[2] & ~btn_q[2];
   assign ev_start = btn_s[1] & ~btn_q[1];
   assign ev_lap   = btn_s[0] & ~btn_q[0];

   assign tick    = (presc == TICK_LAST);
   assign running = (st == S_RUN) || (st == S_LAP);
   assign at_term = ctr.ctr_up ? (ctr.count == MAX_COUNT) : (ctr.count == 8'd0);

   assign ctr.ctr_ce  = tick & running & ~at_term;
   assign ctr.ctr_din = MAX_COUNT;
   assign state       = st;

`ifdef STOPWATCH_LAP_EN
   assign display = ((st == S_LAP) || ((st == S_PAUSE) && resume_lap)) ? lap_reg : ctr.count;
`else
   assign display = ctr.count;
`endif

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         btn_s        <= '0;
         btn_q        <= '0;
         st           <= S_IDLE;
         presc        <= '0;
         ctr.ctr_up   <= 1'b1;
         ctr.ctr_sclr <= 1'b0;
         ctr.ctr_load <= 1'b0;
         done         <= 1'b0;
`ifdef STOPWATCH_LAP_EN
         lap_reg      <= '0;
         resume_lap   <= 1'b0;
`endif
      end else begin
         btn_s        <= {btn_clear, btn_start, btn_lap};
         btn_q        <= btn_s;
         ctr.ctr_sclr <= 1'b0;
         ctr.ctr_load <= 1'b0;

         if (ev_clear || (st == S_IDLE) || (st == S_DONE)) begin
            presc <= '0;
         end else if (running) begin
            presc <= tick ? '0 : presc + 23'd1;
         end

         if (ev_clear) begin
            st           <= S_IDLE;
            ctr.ctr_sclr <= 1'b1;
            done         <= 1'b0;
`ifdef STOPWATCH_LAP_EN
            resume_lap   <= 1'b0;
`endif
         end else begin
            case (st)
               S_IDLE: begin
                  if (ev_start) begin
                     st           <= S_RUN;
                     ctr.ctr_up   <= ~dir_dn;
                     ctr.ctr_load <= dir_dn;
                  end
               end
               S_RUN: begin
                  if (ev_start) begin
                     st <= S_PAUSE;
`ifdef STOPWATCH_LAP_EN
                     resume_lap <= 1'b0;
`endif
                  end else if (tick && at_term) begin
                     st   <= S_DONE;
                     done <= 1'b1;
                  end else if (ev_lap) begin
`ifdef STOPWATCH_LAP_EN
                     st      <= S_LAP;
                     lap_reg <= ctr.count;
`endif
                  end
               end
`ifdef STOPWATCH_LAP_EN
               S_LAP: begin
                  if (ev_start) begin
                     st         <= S_PAUSE;
                     resume_lap <= 1'b1;
                  end else if (tick && at_term) begin
                     st   <= S_DONE;
                     done <= 1'b1;
                  end else if (ev_lap) begin
                     st <= S_RUN;
                  end
               end
`endif
               S_PAUSE: begin
                  if (ev_start) begin
`ifdef STOPWATCH_LAP_EN
                     st <= resume_lap ? S_LAP : S_RUN;
`else
                     st <= S_RUN;
`endif
                  end
               end
               S_DONE: begin
                  st <= S_DONE;
               end
               default: st <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the 8-bit stopwatch counter core. It turns debounced front-panel buttons into the counter's control signals: count enable, direction, synchronous clear and preset load. It generates the 1-second count tick from the 5 MHz fabric clock. It also owns the lap-hold display mux. It sits between the button debouncers and the counter core, and runs in the 5 MHz domain.

## Interface
- TICK_DIV, 5_000_000: clk cycles per count tick (1 s at 5 MHz).
- MAX_COUNT, 8'd99: terminal value when counting up; preset value when counting down.
- clk  in  1  5 MHz fabric clock; all logic on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- btn_start  in  1  debounced level; each rising edge toggles run/pause.
- btn_lap  in  1  debounced level; each rising edge toggles lap hold.
- btn_clear  in  1  debounced level; a rising edge returns the block to IDLE.
- dir_dn  in  1  direction select: 0 = up, 1 = down. Sampled only on leaving IDLE.
- count  in  8  current counter core output.
- ctr_ce  out  1  counter clock enable, one-cycle pulse.
- ctr_up  out  1  counter direction: 1 = up.
- ctr_sclr  out  1  counter synchronous clear, one-cycle pulse.
- ctr_load  out  1  counter preset load, one-cycle pulse; counter loads ctr_din.
- ctr_din  out  8  preset value, constant MAX_COUNT.
- display  out  8  value shown on the display: live count, or the frozen lap value.
- state  out  3  encoded FSM state, for LED/debug use.
- done  out  1  high while in DONE.

## Operation
- Edge detect: each button has a registered previous-value flop. The event is `btn & ~btn_q`. An event acts on the cycle after the button edge is sampled.
- Event priority within one cycle: clear > start > lap. Lower-priority events in the same cycle are dropped.
- FSM states: IDLE=0, RUN=1, PAUSE=2, LAP=3, DONE=4.
  - IDLE: on start, latch `ctr_up = ~dir_dn` and go to RUN.
    - Down mode also pulses ctr_load in that cycle.
  - RUN: start -> PAUSE; lap -> LAP (captures lap_reg from count); terminal reached -> DONE.
  - LAP: counter keeps running; display shows lap_reg.
    - lap -> RUN (releases the hold).
    - start -> PAUSE (hold kept; a later resume from PAUSE returns to LAP).
    - terminal -> DONE (hold released).
  - PAUSE: start -> RUN or LAP, whichever was active before the pause.
  - DONE: start and lap are ignored; only clear exits.
  - Any state: clear -> IDLE, with a one-cycle ctr_sclr pulse, lap hold released and prescaler zeroed.
- Prescaler: 23-bit counter runs 0..TICK_DIV-1 in RUN and LAP only. It holds its value in PAUSE, so a resume continues the partial second. It is zeroed in IDLE and DONE. `tick` = prescaler == TICK_DIV-1.
- Terminal: at_term = ctr_up ? (count == MAX_COUNT) : (count == 0).
- ctr_ce = tick & (state is RUN or LAP) & ~at_term.
- Terminal transition: tick while at_term -> DONE. No ctr_ce is issued and count stays at the terminal value.
- display = (state is LAP, or PAUSE resuming to LAP) ? lap_reg : count.

## Timing
- Reset values (reset_n low at a clk edge): state=IDLE, ctr_ce=0, ctr_up=1, ctr_sclr=0, ctr_load=0, done=0, prescaler=0, lap_reg=0, edge flops=0.
- Button edge to state change: 2 clk cycles (sample flop, then FSM register).
- ctr_ce: combinational from registered signals, high for exactly one cycle per TICK_DIV cycles while running.
- First ctr_ce after start from IDLE: TICK_DIV cycles after the FSM enters RUN.
- ctr_sclr and ctr_load are registered, one-cycle pulses, issued in the same cycle the FSM enters IDLE or RUN.
- Clear mid-count: ctr_ce is suppressed in the same cycle ctr_sclr is asserted.
- reset_n low mid-run: returns to the reset values at the next edge. No ctr_sclr is issued, because the counter core is reset by the system reset.

## Configuration
- STOPWATCH_LAP_EN defined: lap feature present, as described above.
- STOPWATCH_LAP_EN undefined:
  - btn_lap is ignored and the LAP state is unreachable.
  - lap_reg is removed.
  - display = count at all times.
  - PAUSE always resumes to RUN.

## Test plan
- Reset then start, dir_dn=0, TICK_DIV=10, MAX_COUNT=5:
  - ctr_ce fires every 10 cycles.
  - At count=5, the next tick enters DONE with no ctr_ce; done=1 and state=4.
- Down mode with MAX_COUNT=5:
  - Start -> ctr_load pulses one cycle, ctr_up=0.
  - At count=0, the next tick enters DONE.
- Pause/resume: pause 3 cycles into the prescaler, wait 50 cycles, resume -> first ctr_ce arrives 7 cycles after RUN is re-entered.
- Lap (STOPWATCH_LAP_EN) at count=3:
  - display holds 3 while count advances to 4 and 5.
  - A second lap -> display follows count.
- Simultaneous clear+start edges in RUN: IDLE, ctr_sclr pulses one cycle, no ctr_ce in that cycle.
- reset_n low in LAP: next edge gives state=0, display=count, ctr_ce=0.
